wpa2_nios2_fast_cpu_debug_cmd_sync: RTL and testbench



---
 rtl/wpa2_nios2_fast_cpu_debug_cmd_sync.sv | 125 ++++++++++++
 tb/tb_wpa2_nios2_fast_cpu_debug_cmd_sync.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wpa2_nios2_fast_cpu_debug_cmd_sync.sv
// System-clock side of the debug slave: synchronises UIR/UDR strobes from TCK and queues {ir, data} commands.
// Optional build macro WPA2_NIOS2_DEBUG_CMD_PARITY_EN drops commands whose even parity over sr fails.
module wpa2_nios2_fast_cpu_debug_cmd_sync #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [SR_W-1:0]            sr,
  input  logic [IR_W-1:0]            ir_in,
  input  logic                       vs_uir,
  input  logic                       vs_udr,
  output logic [SR_W-1:0]            jdo,
  output logic [IR_W-1:0]            st_ir,
  output logic                       uir_pulse,
  output logic                       udr_pulse,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [SR_W-1:0]            cmd_data,
  output logic [$clog2(DEPTH):0]     cmd_level,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic                       parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
  logic                   uir_last, udr_last;
  logic                   uir_rise, udr_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_last <= 1'b0;
      udr_last <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_last <= uir_sync[SYNC_STAGES-1];
      udr_last <= udr_sync[SYNC_STAGES-1];
    end
  end

  assign uir_rise  = uir_sync[SYNC_STAGES-1] & ~uir_last;
  assign udr_rise  = udr_sync[SYNC_STAGES-1] & ~udr_last;
  assign uir_pulse = uir_rise;
  assign udr_pulse = udr_rise;

  logic parity_ok;
`ifdef WPA2_NIOS2_DEBUG_CMD_PARITY_EN
  assign parity_ok = ~(^sr);
`else
  assign parity_ok = 1'b1;
`endif

  // sr and ir_in are quasi-static while their strobe is high, so sampling them on the synchronised edge is safe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_ir <= '0;
      jdo   <= '0;
    end else begin
      if (uir_rise) st_ir <= ir_in;
      if (udr_rise) jdo <= sr;
    end
  end

  logic [IR_W-1:0] ir_mem   [DEPTH];
  logic [SR_W-1:0] data_mem [DEPTH];
  logic [LW-1:0]   wr_ptr, rd_ptr, level;
  logic            full, push_req, push, pop, drop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == LW'(DEPTH));
  assign pop      = cmd_valid & cmd_ready;
  assign push_req = udr_rise & parity_ok;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        // st_ir here is the pre-update value, so a coincident UIR does not leak into this command
        ir_mem[wr_ptr[AW-1:0]]   <= st_ir;
        data_mem[wr_ptr[AW-1:0]] <= sr;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign cmd_valid = (level != '0);
  assign cmd_level = level;
  assign cmd_ir    = ir_mem[rd_ptr[AW-1:0]];
  assign cmd_data  = data_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (ovf_clr) overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
  end

`ifdef WPA2_NIOS2_DEBUG_CMD_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     parity_err <= 1'b0;
    else if (ovf_clr)                 parity_err <= 1'b0;
    else if (udr_rise && !parity_ok)  parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_wpa2_nios2_fast_cpu_debug_cmd_sync.sv
// Directed plus randomized bench for the debug command synchroniser, checked against a queue-based model.
module tb_wpa2_nios2_fast_cpu_debug_cmd_sync;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int S     = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [SR_W-1:0] sr;
  logic [IR_W-1:0] ir_in;
  logic            vs_uir, vs_udr;
  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] st_ir;
  logic            uir_pulse, udr_pulse;
  logic            cmd_valid, cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_data;
  logic [LW-1:0]   cmd_level;
  logic            overflow, ovf_clr, parity_err;

  wpa2_nios2_fast_cpu_debug_cmd_sync #(
    .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(S), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .jdo(jdo), .st_ir(st_ir),
    .uir_pulse(uir_pulse), .udr_pulse(udr_pulse),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .cmd_level(cmd_level), .overflow(overflow),
    .ovf_clr(ovf_clr), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } cmd_t;

  cmd_t            q[$];
  logic [IR_W-1:0] st_m;
  logic [SR_W-1:0] jdo_m;
  bit              ovf_m, par_m;
  bit              exp_uir, exp_udr;
  int              ready_mode;  // 0 hold, 1 random, 2 high only in the UDR pulse cycle
  bit              rand_clr;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit parity_good(logic [SR_W-1:0] d);
`ifdef WPA2_NIOS2_DEBUG_CMD_PARITY_EN
    int ones = 0;
    for (int i = 0; i < SR_W; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [SR_W-1:0] fix(logic [SR_W-1:0] d);
    logic [SR_W-1:0] r = d;
`ifdef WPA2_NIOS2_DEBUG_CMD_PARITY_EN
    r[SR_W-1] = 1'b0;
    if (!parity_good(r)) r[SR_W-1] = 1'b1;
`endif
    return r;
  endfunction

  // Compare against the model at this negedge, then apply what the coming posedge does to the model.
  task automatic cycle();
    bit pop;
    if (ready_mode == 1) cmd_ready = 1'($urandom_range(0, 1));
    if (rand_clr) ovf_clr = ($urandom_range(0, 15) == 0);
    chk("cmd_valid", cmd_valid, q.size() != 0);
    chk("cmd_level", cmd_level, q.size());
    if (q.size() != 0) begin
      chk("cmd_ir", cmd_ir, q[0].ir);
      chk("cmd_data", cmd_data, q[0].data);
    end
    chk("overflow", overflow, ovf_m);
    chk("parity_err", parity_err, par_m);
    chk("jdo", jdo, jdo_m);
    chk("st_ir", st_ir, st_m);
    chk("uir_pulse", uir_pulse, exp_uir);
    chk("udr_pulse", udr_pulse, exp_udr);
    pop = cmd_ready && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (exp_udr) begin
      jdo_m = sr;
      if (!parity_good(sr)) par_m = 1'b1;
      else if (q.size() < DEPTH) q.push_back('{ir: st_m, data: sr});
      else ovf_m = 1'b1;
    end
    if (exp_uir) st_m = ir_in;
    if (ovf_clr) begin
      ovf_m = 1'b0;
      par_m = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic scan(bit do_ir, bit do_dr, logic [IR_W-1:0] ir, logic [SR_W-1:0] d,
                      int extra_hi, int extra_lo);
    ir_in  = ir;
    sr     = d;
    vs_uir = do_ir;
    vs_udr = do_dr;
    for (int c = 0; c < S + 1 + extra_hi; c++) begin
      exp_uir = do_ir && (c == S);
      exp_udr = do_dr && (c == S);
      if (ready_mode == 2) cmd_ready = (c == S);
      cycle();
    end
    exp_uir = 1'b0;
    exp_udr = 1'b0;
    vs_uir  = 1'b0;
    vs_udr  = 1'b0;
    if (ready_mode == 2) cmd_ready = 1'b0;
    for (int c = 0; c < S + 1 + extra_lo; c++) cycle();
  endtask

  task automatic drain_all();
    ready_mode = 0;
    cmd_ready  = 1'b1;
    idle(DEPTH + 1);
    cmd_ready  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sr = '0; ir_in = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    cmd_ready = 1'b0; ovf_clr = 1'b0;
    st_m = '0; jdo_m = '0; ovf_m = 1'b0; par_m = 1'b0;
    exp_uir = 1'b0; exp_udr = 1'b0; ready_mode = 0; rand_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_level", cmd_level, 0);
    chk("rst_jdo", jdo, 0);
    reset_n = 1'b1;
    idle(2);

    // IR then DR with consumer stalled
    scan(1'b1, 1'b0, 2'b10, '0, 1, 0);
    scan(1'b0, 1'b1, 2'b00, fix(38'h15_A5A5_A5A5), 1, 0);
    chk("irdr_cmd_ir", cmd_ir, 2'b10);
    chk("irdr_cmd_data", cmd_data, fix(38'h15_A5A5_A5A5));
    chk("irdr_level", cmd_level, 1);
    drain_all();

    // Overflow: five scans into a four-entry FIFO
    for (int i = 1; i <= 5; i++) scan(1'b0, 1'b1, 2'b00, fix(SR_W'(i)), 0, 0);
    chk("ovf_level", cmd_level, DEPTH);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_jdo", jdo, fix(SR_W'(5)));
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", cmd_data, fix(SR_W'(i)));
      cmd_ready = 1'b1;
      cycle();
      cmd_ready = 1'b0;
    end
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 1'b0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 11; i <= 14; i++) scan(1'b0, 1'b1, 2'b01, fix(SR_W'(i)), 0, 0);
    ready_mode = 2;
    scan(1'b0, 1'b1, 2'b01, fix(SR_W'(15)), 0, 0);
    ready_mode = 0;
    chk("pp_level", cmd_level, DEPTH);
    chk("pp_overflow", overflow, 1'b0);
    for (int i = 12; i <= 15; i++) begin
      chk("pp_order", cmd_data, fix(SR_W'(i)));
      cmd_ready = 1'b1;
      cycle();
      cmd_ready = 1'b0;
    end

    // ovf_clr held across an overflowing push wins
    for (int i = 21; i <= 24; i++) scan(1'b0, 1'b1, 2'b00, fix(SR_W'(i)), 0, 0);
    ovf_clr = 1'b1;
    scan(1'b0, 1'b1, 2'b00, fix(SR_W'(25)), 0, 0);
    ovf_clr = 1'b0;
    chk("clr_prio", overflow, 1'b0);
    drain_all();

    // Simultaneous UIR and UDR: command carries the old IR
    scan(1'b1, 1'b0, 2'd1, '0, 0, 0);
    scan(1'b1, 1'b1, 2'd3, fix(SR_W'(77)), 0, 0);
    chk("sim_cmd_ir", cmd_ir, 2'd1);
    chk("sim_st_ir", st_ir, 2'd3);
    drain_all();

`ifdef WPA2_NIOS2_DEBUG_CMD_PARITY_EN
    scan(1'b0, 1'b1, 2'b00, fix(SR_W'(99)) ^ {1'b1, {(SR_W-1){1'b0}}}, 0, 0);
    chk("par_err", parity_err, 1'b1);
    chk("par_level", cmd_level, 0);
    chk("par_jdo", jdo, fix(SR_W'(99)) ^ {1'b1, {(SR_W-1){1'b0}}});
    scan(1'b0, 1'b1, 2'b00, fix(SR_W'(98)), 0, 0);
    chk("par_good_level", cmd_level, 1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("par_clr", parity_err, 1'b0);
    drain_all();
`endif

    // Reset mid-operation with three entries queued
    for (int i = 31; i <= 33; i++) scan(1'b0, 1'b1, 2'b00, fix(SR_W'(i)), 0, 0);
    chk("pre_rst_level", cmd_level, 3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", cmd_valid, 1'b0);
    chk("mid_rst_level", cmd_level, 0);
    chk("mid_rst_jdo", jdo, 0);
    chk("mid_rst_st_ir", st_ir, 0);
    q.delete();
    st_m = '0; jdo_m = '0; ovf_m = 1'b0; par_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    scan(1'b0, 1'b1, 2'b00, fix(SR_W'(41)), 0, 0);
    chk("post_rst_data", cmd_data, fix(SR_W'(41)));
    drain_all();

    // Randomized scans, consumer and clears
    ready_mode = 1;
    rand_clr   = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [SR_W-1:0] d;
      kind = $urandom_range(0, 2);
      d = SR_W'({$urandom(), $urandom()});
      if ($urandom_range(0, 7) != 0) d = fix(d);
      scan(kind != 1, kind != 0, IR_W'($urandom()), d,
           $urandom_range(0, 3), $urandom_range(0, 3));
    end
    ready_mode = 0;
    rand_clr   = 1'b0;
    ovf_clr    = 1'b0;
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
